credit_return_fifo: RTL

Receiver-side endpoint of the credit flow-control link whose sender side is the `counter` credit tracker. It buffers incoming words in a DEPTH-entry FIFO and hands them to a downstream consumer through a valid/ready handshake. It returns freed slots to the sender as credit pulses on an `incr`-style interface of up to 3 credits per cycle, batched. After reset it announces the initial credit with a one-cycle `reinit`-style pulse that carries DEPTH.

---
 rtl/credit_return_fifo_if.sv | 25 ++
 rtl/credit_return_fifo.sv | 92 +++++++++
 2 files changed

// File: rtl/credit_return_fifo_if.sv
// Handshake bundle between the credit-return FIFO and its sender/consumer.
// The slave modport is the FIFO side; master is the environment side.
interface credit_return_fifo_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             credit_init;
    logic [3:0]       credit_init_value;
    logic             credit_valid;
    logic [1:0]       credit;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, credit_init, credit_init_value, credit_valid, credit
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, credit_init, credit_init_value, credit_valid, credit
    );
endinterface

// File: rtl/credit_return_fifo.sv
// Receiver endpoint of a credit link: buffers pushed words, serves them on valid/ready,
// and returns freed slots to the sender in batches of up to 3 credits per cycle.
module credit_return_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MIN_BATCH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    credit_return_fifo_if.slave   bus,
    output logic [3:0]            occupancy,
    output logic                  overflow
);
    localparam int unsigned     PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      DepthV    = 4'(DEPTH);
    localparam logic [3:0]      MinBatchV = 4'(MIN_BATCH);
    localparam logic [PtrW-1:0] LastPtr   = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [3:0]       occ_q, occ_d;
    logic [3:0]       pend_q, pend_d;
    logic             overflow_q;
    logic             init_done_q;

    logic             empty, full, pop, push_ok, push_drop;
    logic             ret_valid;
    logic [1:0]       ret_cnt;

    assign empty     = (occ_q == 4'd0);
    assign full      = (occ_q == DepthV);
    assign pop       = !empty && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = bus.in_valid && (!full || pop);
    assign push_drop = bus.in_valid && full && !pop;

    always_comb begin
        ret_valid = (pend_q >= MinBatchV) || ((pend_q != 4'd0) && empty);
        ret_cnt   = 2'd0;
        if (ret_valid) begin
            ret_cnt = (pend_q >= 4'd3) ? 2'd3 : pend_q[1:0];
        end
        occ_d  = occ_q + {3'b000, push_ok} - {3'b000, pop};
        pend_d = pend_q + {3'b000, pop} - {2'b00, ret_cnt};
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= 4'd0;
            pend_q      <= 4'd0;
            overflow_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            occ_q       <= occ_d;
            pend_q      <= pend_d;
            init_done_q <= 1'b1;
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Gated by rst_n so the announcement is low while reset is held.
    assign bus.credit_init       = rst_n && !init_done_q;
    assign bus.credit_init_value = bus.credit_init ? DepthV : 4'd0;
    assign bus.credit_valid      = ret_valid;
    assign bus.credit            = ret_cnt;
    assign bus.out_valid         = !empty;
    assign bus.out_data          = empty ? '0 : mem_q[rd_ptr_q];
    assign occupancy             = occ_q;
    assign overflow              = overflow_q;

    // Local bounds only; end-to-end conservation also involves the sender's counter.
    a_bounds: assert property (@(posedge clk) disable iff (!rst_n)
        (occ_q <= DepthV) && (pend_q <= DepthV));
    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        ret_valid |-> ((ret_cnt != 2'd0) && ({2'b00, ret_cnt} <= pend_q)));
endmodule
